// File: rtl/step_burst_gate.sv
// Gates a free-running step pulse train into key-started bursts of a quarter, half or full
// revolution (or continuous), with a one-deep request queue, abort, done pulse and remaining count.
module step_burst_gate #(
   parameter int STEPS_PER_REV = 200,
   parameter int CNT_W         = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_n,
   input  logic [1:0]       turn_sel,
   input  logic             full_step,
   input  logic             abort,
   input  logic             step_in,
   output logic             step_out,
   output logic             busy,
   output logic             pending,
   output logic             done,
   output logic [CNT_W-1:0] remaining
);

   typedef enum logic [1:0] {IDLE, RUN, CONT} burstState;

   burstState        stateQ, stateD;
   logic             keyPrev, press, complete, newCont, queuedCont;
   logic [CNT_W-1:0] count, countInc, target, queuedTarget, newTarget;

   function automatic logic [CNT_W-1:0] calcTarget(input logic [1:0] sel, input logic fullStep);
      logic [CNT_W-1:0] base;
      case (sel)
         2'b00:   base = CNT_W'(STEPS_PER_REV / 4);
         2'b01:   base = CNT_W'(STEPS_PER_REV / 2);
         default: base = CNT_W'(STEPS_PER_REV);
      endcase
      return fullStep ? base : base << 1;
   endfunction

   assign press     = ~key_n & keyPrev;
   assign newTarget = calcTarget(turn_sel, full_step);
   assign newCont   = (turn_sel == 2'b11);
   assign countInc  = count + 1'b1;
   assign complete  = (stateQ == RUN) && step_in && (countInc == target);

   // Reset as "held" so a key already down when reset lifts must be released before it can start a burst.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) keyPrev <= 1'b0;
      else      keyPrev <= key_n;
   end

   // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) stateQ <= IDLE;
      else      stateQ <= stateD;
   end

   // NOTE: stateD gets a default before any branch so no latch is inferred.
   always_comb begin
      stateD = stateQ;
      if (abort) begin
         stateD = IDLE;
      end else begin
         case (stateQ)
            IDLE: if (press) stateD = newCont ? CONT : RUN;
            RUN: begin
               if (complete) begin
                  if (pending)    stateD = queuedCont ? CONT : RUN;
                  else if (press) stateD = newCont ? CONT : RUN;
                  else            stateD = IDLE;
               end
            end
            CONT:    if (press) stateD = IDLE;
            default: stateD = IDLE;
         endcase
      end
   end

   always_comb begin
      busy     = (stateQ != IDLE);
      step_out = step_in & busy;
   end

   // Priority: abort, then completion, then press; a press only reaches the queue if not completing.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count        <= '0;
         target       <= '0;
         queuedTarget <= '0;
         queuedCont   <= 1'b0;
         pending      <= 1'b0;
         done         <= 1'b0;
         remaining    <= '0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            done      <= busy;
            pending   <= 1'b0;
            count     <= '0;
            remaining <= '0;
         end else begin
            case (stateQ)
               IDLE: begin
                  if (press) begin
                     count     <= '0;
                     target    <= newTarget;
                     remaining <= newCont ? '0 : newTarget;
                  end
               end
               RUN: begin
                  if (complete) begin
                     done  <= 1'b1;
                     count <= '0;
                     if (pending) begin
                        pending   <= 1'b0;
                        target    <= queuedTarget;
                        remaining <= queuedCont ? '0 : queuedTarget;
                     end else if (press) begin
                        target    <= newTarget;
                        remaining <= newCont ? '0 : newTarget;
                     end else begin
                        remaining <= '0;
                     end
                  end else begin
                     if (step_in) begin
                        count     <= countInc;
                        remaining <= target - countInc;
                     end
                     if (press && !pending) begin
                        pending      <= 1'b1;
                        queuedTarget <= newTarget;
                        queuedCont   <= newCont;
                     end
                  end
               end
               CONT: begin
                  if (press) begin
                     done  <= 1'b1;
                     count <= '0;
                  end else if (step_in) begin
                     count <= countInc;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
